// File: rtl/arbitro_d1_pkg.sv
// rtl/arbitro_d1_pkg.sv - shared constants for the arbitro_d1 d1-FIFO scheduler
// Contents: one-hot FSM state encodings, source count, default d1 thresholds.
package arbitro_d1_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam logic [1:0] AF_DEFAULT = 2'b11;
    localparam logic [1:0] AE_DEFAULT = 2'b01;

endpackage

// File: rtl/rr_sel_d1.sv
// rtl/rr_sel_d1.sv - combinational round-robin selector
// Ports:
//   req       in  one request bit per source
//   ptr       in  index granted last; the scan starts at ptr+1
//   grant     out one-hot grant (zero when no request)
//   grant_idx out binary index of the granted source
//   any       out at least one request present
module rr_sel_d1 #(
    parameter int NUM_REQ = arbitro_d1_pkg::NUM_REQ,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);
    import arbitro_d1_pkg::*;

    int idx;

    // Scan ptr+1, ptr+2, ... with wrap-around; the first hit wins, so the
    // source granted last has the lowest priority next time.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/arbitro_d1.sv
// rtl/arbitro_d1.sv - round-robin drain of four source FIFOs into the d1 FIFO
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   init                level; loads thresholds while the FSM sits in INIT
//   umbral_af_in/ae_in  thresholds to program into afD_o/aeD_o
//   fifo_empty_in       per-source empty flags
//   data_in             per-source registered pop data, slice i = [i*DATA_SIZE +: DATA_SIZE]
//   fifo_pause_d1       d1 almost-full backpressure
//   fifo_error_d1       d1 overflow/underflow flag, latched into error
//   pop_req             one-hot pop to the sources
//   push_d1, data_d1    push to d1, one cycle after the pop
//   afD_o, aeD_o        programmed d1 thresholds
//   state, idle, error  one-hot FSM state, idle indication, sticky error
module arbitro_d1 #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [1:0]                   umbral_af_in,
    input  logic [1:0]                   umbral_ae_in,
    input  logic [NUM_REQ-1:0]           fifo_empty_in,
    input  logic [NUM_REQ*DATA_SIZE-1:0] data_in,
    input  logic                         fifo_pause_d1,
    input  logic                         fifo_error_d1,
    output logic [NUM_REQ-1:0]           pop_req,
    output logic                         push_d1,
    output logic [DATA_SIZE-1:0]         data_d1,
    output logic [1:0]                   afD_o,
    output logic [1:0]                   aeD_o,
    output logic [3:0]                   state,
    output logic                         idle,
    output logic                         error
);
    import arbitro_d1_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [3:0]           state_q, state_d;
    logic [1:0]           af_q, af_d, ae_q, ae_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic                 push_valid_q, push_valid_d;
    logic [DATA_SIZE-1:0] data_q, data_d, data_sel;
    logic                 error_q, error_d;

    logic [NUM_REQ-1:0]   sel_grant;
    logic [IW-1:0]        sel_idx;
    logic                 sel_any;
    logic                 pop_ok;

    rr_sel_d1 #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_sel (
        .req       (~fifo_empty_in),
        .ptr       (rr_ptr_q),
        .grant     (sel_grant),
        .grant_idx (sel_idx),
        .any       (sel_any)
    );

    // init also blocks the pop in the very cycle it rises, so nothing new is
    // started while the FSM heads into INIT.
    assign pop_ok  = (state_q == ST_ACTIVE) && !fifo_pause_d1 && !init && sel_any;
    assign pop_req = pop_ok ? sel_grant : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)
                    state_d = ST_INIT;
                else if (!(&fifo_empty_in) && !fifo_pause_d1)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)
                    state_d = ST_INIT;
                else if ((&fifo_empty_in) || fifo_pause_d1)
                    state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        af_d = af_q;
        ae_d = ae_q;
        if ((state_q == ST_INIT) && init) begin
            af_d = umbral_af_in;
            ae_d = umbral_ae_in;
        end
    end

    // The source FIFOs present popped data one cycle after the pop, so the
    // grant is registered and the slice is selected in the push cycle.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(grant_q) == i)
                data_sel = data_in[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign rr_ptr_d     = pop_ok ? sel_idx : rr_ptr_q;
    assign grant_d      = pop_ok ? sel_idx : grant_q;
    assign push_valid_d = pop_ok;
    // data_q keeps the last pushed word so data_d1 holds between pushes.
    assign data_d       = data_d1;
    assign error_d      = error_q | fifo_error_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RESET;
            af_q         <= AF_DEFAULT;
            ae_q         <= AE_DEFAULT;
            rr_ptr_q     <= IW'(NUM_REQ - 1);
            grant_q      <= '0;
            push_valid_q <= 1'b0;
            data_q       <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            push_valid_q <= push_valid_d;
            data_q       <= data_d;
            error_q      <= error_d;
        end
    end

    assign push_d1 = push_valid_q;
    assign data_d1 = push_valid_q ? data_sel : data_q;
    assign afD_o   = af_q;
    assign aeD_o   = ae_q;
    assign state   = state_q;
    assign idle    = (state_q == ST_IDLE) && !push_valid_q;
    assign error   = error_q;

endmodule

// File: tb/tb_arbitro_d1.sv
// tb/tb_arbitro_d1.sv - self-checking bench for arbitro_d1
module tb_arbitro_d1;

    localparam logic [3:0] S_RST = 4'b0001;
    localparam logic [3:0] S_INI = 4'b0010;
    localparam logic [3:0] S_IDL = 4'b0100;
    localparam logic [3:0] S_ACT = 4'b1000;

    logic        clk = 1'b0;
    logic        reset, init, fifo_pause_d1, fifo_error_d1;
    logic [1:0]  umbral_af_in, umbral_ae_in;
    logic [3:0]  fifo_empty_in;
    logic [31:0] data_in;
    logic [3:0]  pop_req;
    logic        push_d1;
    logic [7:0]  data_d1;
    logic [1:0]  afD_o, aeD_o;
    logic [3:0]  state;
    logic        idle, error;

    always #5 clk = ~clk;

    arbitro_d1 #(.DATA_SIZE(8), .NUM_REQ(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_af_in  (umbral_af_in),
        .umbral_ae_in  (umbral_ae_in),
        .fifo_empty_in (fifo_empty_in),
        .data_in       (data_in),
        .fifo_pause_d1 (fifo_pause_d1),
        .fifo_error_d1 (fifo_error_d1),
        .pop_req       (pop_req),
        .push_d1       (push_d1),
        .data_d1       (data_d1),
        .afD_o         (afD_o),
        .aeD_o         (aeD_o),
        .state         (state),
        .idle          (idle),
        .error         (error)
    );

    // Source FIFOs: contents plus the registered pop-data output.
    logic [7:0] srcq [4][$];
    logic [7:0] dout [4];

    int n_cmp = 0;
    int n_bad = 0;

    // Outputs sampled mid-cycle.
    logic [3:0] a_pop, a_state;
    logic       a_push, a_idle, a_err;
    logic [7:0] a_data;
    logic [1:0] a_af, a_ae;

    // Transaction-level reference: last granted source, word in flight,
    // word last handed to d1, thresholds, error and spec-level state.
    logic [3:0] m_state;
    int         m_last;
    bit         m_pend;
    logic [7:0] m_pword, m_out;
    bit         m_err;
    logic [1:0] m_af, m_ae;

    typedef struct {
        bit         rst;
        bit         ini;
        logic [3:0] mask;
        logic [31:0] words;
        logic [3:0] e_state;
        logic [3:0] e_pop;
        bit         e_push;
        logic [7:0] e_data;
        bit         e_idle;
        logic [1:0] e_af;
        logic [1:0] e_ae;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(bit rst, bit ini, logic [3:0] mask, logic [31:0] words,
                                logic [3:0] st, logic [3:0] pop, bit push, logic [7:0] data,
                                bit idl, logic [1:0] af, logic [1:0] ae);
        vec_t v;
        v.rst = rst; v.ini = ini; v.mask = mask; v.words = words;
        v.e_state = st; v.e_pop = pop; v.e_push = push; v.e_data = data;
        v.e_idle = idl; v.e_af = af; v.e_ae = ae;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void refresh_inputs();
        for (int i = 0; i < 4; i++) begin
            fifo_empty_in[i]  = (srcq[i].size() == 0);
            data_in[i*8 +: 8] = dout[i];
        end
    endfunction

    function automatic void model_reset();
        m_state = S_RST; m_last = 3; m_pend = 0; m_pword = 8'h00; m_out = 8'h00;
        m_err = 0; m_af = 2'b11; m_ae = 2'b01;
    endfunction

    task automatic model_step();
        int g;
        int idx;
        logic [3:0] e_pop;
        logic [3:0] nst;
        g = -1;
        e_pop = 4'b0;
        if (m_state == S_ACT && !fifo_pause_d1 && !init) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (g < 0 && srcq[idx].size() > 0) g = idx;
            end
        end
        if (g >= 0) e_pop[g] = 1'b1;
        chk("m_pop_req", 32'(a_pop), 32'(e_pop));
        chk("m_push_d1", 32'(a_push), 32'(m_pend));
        chk("m_data_d1", 32'(a_data), 32'(m_pend ? m_pword : m_out));
        chk("m_state", 32'(a_state), 32'(m_state));
        chk("m_idle", 32'(a_idle), 32'(m_state == S_IDL && !m_pend));
        chk("m_error", 32'(a_err), 32'(m_err));
        chk("m_afD", 32'(a_af), 32'(m_af));
        chk("m_aeD", 32'(a_ae), 32'(m_ae));
        if (reset) begin
            model_reset();
        end else begin
            if (m_pend) m_out = m_pword;
            if (g >= 0) begin
                m_pend = 1; m_pword = srcq[g][0]; m_last = g;
            end else begin
                m_pend = 0;
            end
            if (fifo_error_d1) m_err = 1;
            if (m_state == S_INI && init) begin
                m_af = umbral_af_in; m_ae = umbral_ae_in;
            end
            nst = m_state;
            if (m_state == S_RST)
                nst = S_INI;
            else if (m_state == S_INI)
                nst = init ? S_INI : S_IDL;
            else if (init)
                nst = S_INI;
            else if (m_state == S_IDL && !(&fifo_empty_in) && !fifo_pause_d1)
                nst = S_ACT;
            else if (m_state == S_ACT && ((&fifo_empty_in) || fifo_pause_d1))
                nst = S_IDL;
            m_state = nst;
        end
    endtask

    task automatic cycle(input bit rst, input bit ini, input bit pau, input bit err,
                         input logic [3:0] mask, input logic [31:0] words);
        reset = rst; init = ini; fifo_pause_d1 = pau; fifo_error_d1 = err;
        for (int i = 0; i < 4; i++)
            if (mask[i]) srcq[i].push_back(words[i*8 +: 8]);
        refresh_inputs();
        @(negedge clk);
        a_pop = pop_req; a_push = push_d1; a_data = data_d1; a_state = state;
        a_idle = idle; a_err = error; a_af = afD_o; a_ae = aeD_o;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a_pop[i]) begin
                chk("pop_src_nonempty", 32'(srcq[i].size() > 0), 32'd1);
                if (srcq[i].size() > 0) dout[i] = srcq[i].pop_front();
            end
        end
        refresh_inputs();
    endtask

    initial begin
        logic [3:0]  rmask;
        logic [31:0] rwords;

        reset = 1'b1; init = 1'b0; fifo_pause_d1 = 1'b0; fifo_error_d1 = 1'b0;
        umbral_af_in = 2'd2; umbral_ae_in = 2'd1;
        for (int i = 0; i < 4; i++) dout[i] = 8'h00;
        refresh_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Init sequence, four single-word sources, then one source with three words.
        tbl[0]  = mk(1, 0, 4'h0, 32'h0,        S_RST, 4'h0, 0, 8'h00, 0, 2'd3, 2'd1);
        tbl[1]  = mk(0, 1, 4'h0, 32'h0,        S_RST, 4'h0, 0, 8'h00, 0, 2'd3, 2'd1);
        tbl[2]  = mk(0, 1, 4'h0, 32'h0,        S_INI, 4'h0, 0, 8'h00, 0, 2'd3, 2'd1);
        tbl[3]  = mk(0, 0, 4'h0, 32'h0,        S_INI, 4'h0, 0, 8'h00, 0, 2'd2, 2'd1);
        tbl[4]  = mk(0, 0, 4'hF, 32'hD3C2B1A0, S_IDL, 4'h0, 0, 8'h00, 1, 2'd2, 2'd1);
        tbl[5]  = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h1, 0, 8'h00, 0, 2'd2, 2'd1);
        tbl[6]  = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h2, 1, 8'hA0, 0, 2'd2, 2'd1);
        tbl[7]  = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h4, 1, 8'hB1, 0, 2'd2, 2'd1);
        tbl[8]  = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h8, 1, 8'hC2, 0, 2'd2, 2'd1);
        tbl[9]  = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h0, 1, 8'hD3, 0, 2'd2, 2'd1);
        tbl[10] = mk(0, 0, 4'h4, 32'h00110000, S_IDL, 4'h0, 0, 8'hD3, 1, 2'd2, 2'd1);
        tbl[11] = mk(0, 0, 4'h4, 32'h00220000, S_ACT, 4'h4, 0, 8'hD3, 0, 2'd2, 2'd1);
        tbl[12] = mk(0, 0, 4'h4, 32'h00330000, S_ACT, 4'h4, 1, 8'h11, 0, 2'd2, 2'd1);
        tbl[13] = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h4, 1, 8'h22, 0, 2'd2, 2'd1);
        tbl[14] = mk(0, 0, 4'h0, 32'h0,        S_ACT, 4'h0, 1, 8'h33, 0, 2'd2, 2'd1);
        tbl[15] = mk(0, 0, 4'h0, 32'h0,        S_IDL, 4'h0, 0, 8'h33, 1, 2'd2, 2'd1);

        for (int r = 0; r < 16; r++) begin
            cycle(tbl[r].rst, tbl[r].ini, 0, 0, tbl[r].mask, tbl[r].words);
            chk($sformatf("t_state[%0d]", r), 32'(a_state), 32'(tbl[r].e_state));
            chk($sformatf("t_pop[%0d]", r),   32'(a_pop),   32'(tbl[r].e_pop));
            chk($sformatf("t_push[%0d]", r),  32'(a_push),  32'(tbl[r].e_push));
            chk($sformatf("t_data[%0d]", r),  32'(a_data),  32'(tbl[r].e_data));
            chk($sformatf("t_idle[%0d]", r),  32'(a_idle),  32'(tbl[r].e_idle));
            chk($sformatf("t_af[%0d]", r),    32'(a_af),    32'(tbl[r].e_af));
            chk($sformatf("t_ae[%0d]", r),    32'(a_ae),    32'(tbl[r].e_ae));
        end

        // Backpressure right after a pop of source 1; last grant was source 2.
        for (int k = 0; k < 8; k++) begin
            srcq[1].push_back(8'h40 + 8'(k));
            srcq[3].push_back(8'h60 + 8'(k));
        end
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t4_idle_state", 32'(a_state), 32'(S_IDL));
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t4_pop_src3", 32'(a_pop), 32'h8);
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t4_pop_src1", 32'(a_pop), 32'h2);
        chk("t4_push_60", 32'(a_data), 32'h60);
        cycle(0, 0, 1, 0, 4'h0, 32'h0);
        chk("t4_pause_pop", 32'(a_pop), 32'h0);
        chk("t4_pause_push", 32'(a_push), 32'h1);
        chk("t4_pause_data", 32'(a_data), 32'h40);
        cycle(0, 0, 1, 0, 4'h0, 32'h0);
        chk("t4_paused_pop", 32'(a_pop), 32'h0);
        chk("t4_paused_state", 32'(a_state), 32'(S_IDL));
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t4_resume_src3", 32'(a_pop), 32'h8);

        // Sticky error through traffic, cleared only by reset.
        cycle(0, 0, 0, 1, 4'h0, 32'h0);
        chk("t5_err_before", 32'(a_err), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 4'h0, 32'h0);
            chk($sformatf("t5_err_sticky[%0d]", k), 32'(a_err), 32'h1);
        end
        cycle(1, 0, 0, 0, 4'h0, 32'h0);
        cycle(1, 0, 0, 0, 4'h0, 32'h0);
        chk("t5_rst_state", 32'(a_state), 32'(S_RST));
        chk("t5_rst_err", 32'(a_err), 32'h0);
        chk("t5_rst_push", 32'(a_push), 32'h0);
        cycle(0, 1, 0, 0, 4'h0, 32'h0);
        cycle(0, 1, 0, 0, 4'h0, 32'h0);
        cycle(0, 0, 0, 0, 4'h0, 32'h0);

        // init raised while ACTIVE, with a push in flight from the previous pop.
        umbral_af_in = 2'd1; umbral_ae_in = 2'd2;
        for (int k = 0; k < 4; k++) srcq[0].push_back(8'h70 + 8'(k));
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t6_idle", 32'(a_state), 32'(S_IDL));
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t6_pop_src0", 32'(a_pop), 32'h1);
        cycle(0, 1, 0, 0, 4'h0, 32'h0);
        chk("t6_pop_blocked", 32'(a_pop), 32'h0);
        chk("t6_push_done", 32'(a_push), 32'h1);
        chk("t6_push_data", 32'(a_data), 32'h70);
        cycle(0, 1, 0, 0, 4'h0, 32'h0);
        chk("t6_state_init", 32'(a_state), 32'(S_INI));
        chk("t6_no_push", 32'(a_push), 32'h0);
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        chk("t6_af", 32'(a_af), 32'h1);
        chk("t6_ae", 32'(a_ae), 32'h2);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            rmask  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rwords = $urandom;
            for (int i = 0; i < 4; i++)
                if (srcq[i].size() >= 8) rmask[i] = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                umbral_af_in = 2'($urandom_range(0, 3));
                umbral_ae_in = 2'($urandom_range(0, 3));
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0),
                  rmask, rwords);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
